// File: rtl/proc_pkg.sv
// Shared datapath constants for the processor core.
// Register file widths and the hardwired-zero register index live here.
package proc_pkg;

   localparam int WORD_W     = 32;
   localparam int NREGS      = 32;
   localparam int REG_ADDR_W = 5;
   localparam int REG_ZERO   = 0;

   typedef logic [WORD_W-1:0]     word_t;
   typedef logic [REG_ADDR_W-1:0] reg_addr_t;

endpackage

// File: rtl/reg_file_if.sv
// Decode/writeback facing bus of the register file.
// Master drives addresses, write data and issue marks; slave returns read data and busy flags.
interface reg_file_if
   import proc_pkg::*;
#(
   parameter int WIDTH  = WORD_W,
   parameter int ADDR_W = REG_ADDR_W
);

   logic              we;
   logic [ADDR_W-1:0] waddr;
   logic [WIDTH-1:0]  wdata;
   logic [ADDR_W-1:0] raddr_a;
   logic [WIDTH-1:0]  rdata_a;
   logic              rbusy_a;
   logic [ADDR_W-1:0] raddr_b;
   logic [WIDTH-1:0]  rdata_b;
   logic              rbusy_b;
   logic              set_busy;
   logic [ADDR_W-1:0] set_addr;

   modport master (
      output we, waddr, wdata, raddr_a, raddr_b, set_busy, set_addr,
      input  rdata_a, rbusy_a, rdata_b, rbusy_b
   );

   modport slave (
      input  we, waddr, wdata, raddr_a, raddr_b, set_busy, set_addr,
      output rdata_a, rbusy_a, rdata_b, rbusy_b
   );

endinterface

// File: rtl/reg_file_scoreboard.sv
// Pending-write tracker: one busy bit per register, set on issue, cleared on writeback.
// Set beats clear on the same register because the newly issued producer is still in flight.
module reg_file_scoreboard
   import proc_pkg::*;
#(
   parameter int DEPTH    = NREGS,
   parameter int ZERO_REG = 1,
   parameter int BYPASS   = 1,
   parameter int ADDR_W   = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              set,
   input  logic [ADDR_W-1:0] set_addr,
   input  logic              clr,
   input  logic [ADDR_W-1:0] clr_addr,
   input  logic [ADDR_W-1:0] raddr_a,
   input  logic [ADDR_W-1:0] raddr_b,
   output logic              rbusy_a,
   output logic              rbusy_b
);

   localparam logic [ADDR_W:0]   DEPTH_L   = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(REG_ZERO);

   logic [DEPTH-1:0] busy;
   logic [DEPTH-1:0] busyNext;
   logic             setOk;

   function automatic logic inRange(input logic [ADDR_W-1:0] a);
      return {1'b0, a} < DEPTH_L;
   endfunction

   // The zero register never has a producer, so issue marks against it are dropped.
   assign setOk = set && inRange(set_addr) && !((ZERO_REG != 0) && (set_addr == ZERO_ADDR));

   // Clear first, then set, so a same-register collision leaves the bit high.
   always_comb begin
      busyNext = busy;
      if (clr) begin
         busyNext[clr_addr] = 1'b0;
      end
      if (setOk) begin
         busyNext[set_addr] = 1'b1;
      end
   end

   // Busy vector, wiped by the asynchronous reset.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         busy <= '0;
      end else begin
         busy <= busyNext;
      end
   end

   // A writeback landing this cycle already satisfies the reader unless it is re-issued too.
   assign rbusy_a = inRange(raddr_a) &&
                    (((BYPASS != 0) && clr && (clr_addr == raddr_a)) ?
                       (setOk && (set_addr == raddr_a)) : busy[raddr_a]);

   assign rbusy_b = inRange(raddr_b) &&
                    (((BYPASS != 0) && clr && (clr_addr == raddr_b)) ?
                       (setOk && (set_addr == raddr_b)) : busy[raddr_b]);

endmodule

// File: rtl/reg_file.sv
// General-purpose register file: one synchronous write port, two combinational read ports,
// optional write-to-read bypass and hardwired zero register, plus a RAW hazard scoreboard.
module reg_file
   import proc_pkg::*;
#(
   parameter int WIDTH    = WORD_W,
   parameter int DEPTH    = NREGS,
   parameter int ZERO_REG = 1,
   parameter int BYPASS   = 1,
   parameter int ADDR_W   = $clog2(DEPTH)
) (
   input  logic      clk,
   input  logic      reset,
   reg_file_if.slave bus
);

   localparam logic [ADDR_W:0]   DEPTH_L   = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(REG_ZERO);

   logic [WIDTH-1:0] regs [DEPTH];
   logic             wrOk;
   logic             setReq;
   logic             bypA;
   logic             bypB;

   // True for addresses that hold real storage: in range and not the hardwired zero.
   function automatic logic addrLegal(input logic [ADDR_W-1:0] a);
      return ({1'b0, a} < DEPTH_L) && !((ZERO_REG != 0) && (a == ZERO_ADDR));
   endfunction

   // Reset masks the write port so nothing leaks through the bypass while it is held.
   assign wrOk   = bus.we && addrLegal(bus.waddr) && !reset;
   assign setReq = bus.set_busy && !reset;

   // Register storage.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            regs[i] <= '0;
         end
      end else if (wrOk) begin
         regs[bus.waddr] <= bus.wdata;
      end
   end

   assign bypA = (BYPASS != 0) && wrOk && (bus.waddr == bus.raddr_a);
   assign bypB = (BYPASS != 0) && wrOk && (bus.waddr == bus.raddr_b);

   assign bus.rdata_a = !addrLegal(bus.raddr_a) ? '0 : (bypA ? bus.wdata : regs[bus.raddr_a]);
   assign bus.rdata_b = !addrLegal(bus.raddr_b) ? '0 : (bypB ? bus.wdata : regs[bus.raddr_b]);

   reg_file_scoreboard #(
      .DEPTH    (DEPTH),
      .ZERO_REG (ZERO_REG),
      .BYPASS   (BYPASS),
      .ADDR_W   (ADDR_W)
   ) u_scoreboard (
      .clk      (clk),
      .reset    (reset),
      .set      (setReq),
      .set_addr (bus.set_addr),
      .clr      (wrOk),
      .clr_addr (bus.waddr),
      .raddr_a  (bus.raddr_a),
      .raddr_b  (bus.raddr_b),
      .rbusy_a  (bus.rbusy_a),
      .rbusy_b  (bus.rbusy_b)
   );

endmodule

// File: tb/tb_reg_file.sv
// Bench for reg_file: dut0 uses the default configuration, dut1 has DEPTH=20, no zero register, no bypass.
// Both see identical stimulus; expectations are queued at drive time and popped after settling.
module tb_reg_file;

   typedef struct {
      logic        rst;
      logic        we;
      logic [4:0]  waddr;
      logic [31:0] wdata;
      logic [4:0]  raddrA;
      logic [4:0]  raddrB;
      logic        setBusy;
      logic [4:0]  setAddr;
   } stim_t;

   typedef struct {
      stim_t       s;
      logic [31:0] rdA;
      logic [31:0] rdB;
      logic        bA;
      logic        bB;
   } vec_t;

   typedef struct {
      int          dut;
      string       name;
      logic [31:0] rdA;
      logic [31:0] rdB;
      logic        bA;
      logic        bB;
   } exp_t;

   logic        clk;
   logic        reset;
   logic        we;
   logic [4:0]  waddr;
   logic [31:0] wdata;
   logic [4:0]  raddrA;
   logic [4:0]  raddrB;
   logic        setBusy;
   logic [4:0]  setAddr;

   int   errors = 0;
   int   checks = 0;
   exp_t sbQueue[$];
   vec_t vecs[20];

   int   cfgDepth[2]  = '{32, 20};
   bit   cfgZero[2]   = '{1'b1, 1'b0};
   bit   cfgBypass[2] = '{1'b1, 1'b0};
   logic [31:0] mRegs[2][32];
   bit          mBusy[2][32];

   reg_file_if #(.WIDTH(32), .ADDR_W(5)) bus0 ();
   reg_file_if #(.WIDTH(32), .ADDR_W(5)) bus1 ();

   assign bus0.we = we;          assign bus1.we = we;
   assign bus0.waddr = waddr;    assign bus1.waddr = waddr;
   assign bus0.wdata = wdata;    assign bus1.wdata = wdata;
   assign bus0.raddr_a = raddrA; assign bus1.raddr_a = raddrA;
   assign bus0.raddr_b = raddrB; assign bus1.raddr_b = raddrB;
   assign bus0.set_busy = setBusy; assign bus1.set_busy = setBusy;
   assign bus0.set_addr = setAddr; assign bus1.set_addr = setAddr;

   reg_file #(.WIDTH(32), .DEPTH(32), .ZERO_REG(1), .BYPASS(1)) dut0 (
      .clk(clk), .reset(reset), .bus(bus0.slave));

   reg_file #(.WIDTH(32), .DEPTH(20), .ZERO_REG(0), .BYPASS(0)) dut1 (
      .clk(clk), .reset(reset), .bus(bus1.slave));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #5_000_000;
      $display("[TB] FAIL watchdog: simulation did not finish, got timeout want completion");
      $fatal(1, "[TB] watchdog expired");
   end

   function automatic stim_t mkStim(logic rst, logic w, logic [4:0] wa, logic [31:0] wd,
                                    logic [4:0] ra, logic [4:0] rb, logic sb, logic [4:0] sa);
      stim_t s;
      s.rst = rst; s.we = w; s.waddr = wa; s.wdata = wd;
      s.raddrA = ra; s.raddrB = rb; s.setBusy = sb; s.setAddr = sa;
      return s;
   endfunction

   task automatic applyStimulus(input stim_t s);
      reset = s.rst; we = s.we; waddr = s.waddr; wdata = s.wdata;
      raddrA = s.raddrA; raddrB = s.raddrB; setBusy = s.setBusy; setAddr = s.setAddr;
   endtask

   task automatic drive(input stim_t s);
      @(negedge clk);
      applyStimulus(s);
   endtask

   task automatic pushExp(input int dut, input string name, input logic [31:0] a,
                          input logic [31:0] b, input logic ba, input logic bb);
      exp_t e;
      e.dut = dut; e.name = name; e.rdA = a; e.rdB = b; e.bA = ba; e.bB = bb;
      sbQueue.push_back(e);
   endtask

   task automatic checkField(input string name, input int dut, input string field,
                             input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("[TB] FAIL %s dut%0d %s: got %h want %h", name, dut, field, got, want);
      end
   endtask

   // Let the combinational outputs settle, then retire every queued expectation.
   task automatic checkOutput();
      exp_t e;
      #1;
      while (sbQueue.size() > 0) begin
         e = sbQueue.pop_front();
         if (e.dut == 0) begin
            checkField(e.name, 0, "rdata_a", bus0.rdata_a, e.rdA);
            checkField(e.name, 0, "rdata_b", bus0.rdata_b, e.rdB);
            checkField(e.name, 0, "rbusy_a", {31'd0, bus0.rbusy_a}, {31'd0, e.bA});
            checkField(e.name, 0, "rbusy_b", {31'd0, bus0.rbusy_b}, {31'd0, e.bB});
         end else begin
            checkField(e.name, 1, "rdata_a", bus1.rdata_a, e.rdA);
            checkField(e.name, 1, "rdata_b", bus1.rdata_b, e.rdB);
            checkField(e.name, 1, "rbusy_a", {31'd0, bus1.rbusy_a}, {31'd0, e.bA});
            checkField(e.name, 1, "rbusy_b", {31'd0, bus1.rbusy_b}, {31'd0, e.bB});
         end
      end
   endtask

   // Reference model
   function automatic bit legalAddr(int k, logic [4:0] a);
      return (int'(a) < cfgDepth[k]) && !(cfgZero[k] && a == 5'd0);
   endfunction

   function automatic bit wrLegal(int k);
      return !reset && we && legalAddr(k, waddr);
   endfunction

   function automatic bit setLegal(int k);
      return !reset && setBusy && legalAddr(k, setAddr);
   endfunction

   function automatic logic [31:0] expRdata(int k, logic [4:0] a);
      if (!legalAddr(k, a)) return 32'd0;
      if (cfgBypass[k] && wrLegal(k) && waddr == a) return wdata;
      return mRegs[k][a];
   endfunction

   function automatic logic expBusy(int k, logic [4:0] a);
      if (int'(a) >= cfgDepth[k]) return 1'b0;
      if (cfgBypass[k] && wrLegal(k) && waddr == a) return setLegal(k) && setAddr == a;
      return mBusy[k][a];
   endfunction

   task automatic clearModel();
      for (int k = 0; k < 2; k++) begin
         for (int r = 0; r < 32; r++) begin
            mRegs[k][r] = 32'd0;
            mBusy[k][r] = 1'b0;
         end
      end
   endtask

   task automatic modelStep();
      for (int k = 0; k < 2; k++) begin
         if (wrLegal(k)) begin
            mRegs[k][waddr] = wdata;
            mBusy[k][waddr] = 1'b0;
         end
         if (setLegal(k)) mBusy[k][setAddr] = 1'b1;
      end
   endtask

   function automatic logic [4:0] randAddr();
      if ($urandom_range(0, 7) == 0) return 5'($urandom_range(20, 31));
      return 5'($urandom_range(0, 19));
   endfunction

   initial begin
      stim_t s;

      vecs[0]  = '{mkStim(0,1,3,32'h12345678,3,3,0,0), 32'h12345678, 32'h12345678, 0, 0};
      vecs[1]  = '{mkStim(0,0,0,32'h0,3,3,0,0),        32'h12345678, 32'h12345678, 0, 0};
      vecs[2]  = '{mkStim(0,1,0,32'hFFFFFFFF,0,3,0,0), 32'h0,        32'h12345678, 0, 0};
      vecs[3]  = '{mkStim(0,0,0,32'h0,0,0,0,0),        32'h0,        32'h0,        0, 0};
      vecs[4]  = '{mkStim(0,1,7,32'hA5A5A5A5,7,6,0,0), 32'hA5A5A5A5, 32'h0,        0, 0};
      vecs[5]  = '{mkStim(0,0,0,32'h0,7,7,0,0),        32'hA5A5A5A5, 32'hA5A5A5A5, 0, 0};
      vecs[6]  = '{mkStim(0,0,0,32'h0,9,9,1,9),        32'h0,        32'h0,        0, 0};
      vecs[7]  = '{mkStim(0,0,0,32'h0,9,0,0,0),        32'h0,        32'h0,        1, 0};
      vecs[8]  = '{mkStim(0,1,9,32'h99,9,9,0,0),       32'h99,       32'h99,       0, 0};
      vecs[9]  = '{mkStim(0,0,0,32'h0,9,9,0,0),        32'h99,       32'h99,       0, 0};
      vecs[10] = '{mkStim(0,0,0,32'h0,9,9,1,9),        32'h99,       32'h99,       0, 0};
      vecs[11] = '{mkStim(0,0,0,32'h0,9,0,0,0),        32'h99,       32'h0,        1, 0};
      vecs[12] = '{mkStim(0,1,9,32'h111,9,9,1,9),      32'h111,      32'h111,      1, 1};
      vecs[13] = '{mkStim(0,0,0,32'h0,9,9,0,0),        32'h111,      32'h111,      1, 1};
      vecs[14] = '{mkStim(0,0,0,32'h0,0,9,1,0),        32'h0,        32'h111,      0, 1};
      vecs[15] = '{mkStim(0,0,0,32'h0,0,9,0,0),        32'h0,        32'h111,      0, 1};
      vecs[16] = '{mkStim(0,1,9,32'h222,4,9,1,4),      32'h0,        32'h222,      0, 0};
      vecs[17] = '{mkStim(0,0,0,32'h0,4,9,0,0),        32'h0,        32'h222,      1, 0};
      vecs[18] = '{mkStim(0,1,5,32'h55,5,4,0,0),       32'h55,       32'h0,        0, 1};
      vecs[19] = '{mkStim(0,0,0,32'h0,5,5,0,0),        32'h55,       32'h55,       0, 0};

      // Reset state
      applyStimulus(mkStim(1,0,0,32'h0,3,31,0,0));
      pushExp(0, "reset_held", 0, 0, 0, 0);
      pushExp(1, "reset_held", 0, 0, 0, 0);
      checkOutput();
      drive(mkStim(0,0,0,32'h0,3,31,0,0));
      pushExp(0, "reset_released", 0, 0, 0, 0);
      pushExp(1, "reset_released", 0, 0, 0, 0);
      checkOutput();

      // Table-driven directed vectors against dut0
      for (int i = 0; i < 20; i++) begin
         drive(vecs[i].s);
         pushExp(0, $sformatf("vec%0d", i), vecs[i].rdA, vecs[i].rdB, vecs[i].bA, vecs[i].bB);
         checkOutput();
      end

      // Asynchronous reset in the middle of a cycle, with a write pending
      drive(mkStim(0,1,5,32'hDEADBEEF,5,6,1,6));
      drive(mkStim(0,0,0,32'h0,5,6,0,0));
      pushExp(0, "pre_reset", 32'hDEADBEEF, 0, 0, 1);
      pushExp(1, "pre_reset", 32'hDEADBEEF, 0, 0, 1);
      checkOutput();
      #2;
      applyStimulus(mkStim(1,1,5,32'hCAFEF00D,5,6,1,5));
      pushExp(0, "mid_reset", 0, 0, 0, 0);
      pushExp(1, "mid_reset", 0, 0, 0, 0);
      checkOutput();
      drive(mkStim(0,0,0,32'h0,5,6,0,0));
      pushExp(0, "post_reset", 0, 0, 0, 0);
      pushExp(1, "post_reset", 0, 0, 0, 0);
      checkOutput();

      // Bypass versus no-bypass on data and busy
      drive(mkStim(0,1,7,32'h11111111,7,7,0,0));
      pushExp(0, "byp_first", 32'h11111111, 32'h11111111, 0, 0);
      pushExp(1, "byp_first", 0, 0, 0, 0);
      checkOutput();
      drive(mkStim(0,1,7,32'hA5A5A5A5,7,7,0,0));
      pushExp(0, "byp_second", 32'hA5A5A5A5, 32'hA5A5A5A5, 0, 0);
      pushExp(1, "byp_second", 32'h11111111, 32'h11111111, 0, 0);
      checkOutput();
      drive(mkStim(0,0,0,32'h0,7,7,0,0));
      pushExp(0, "byp_after", 32'hA5A5A5A5, 32'hA5A5A5A5, 0, 0);
      pushExp(1, "byp_after", 32'hA5A5A5A5, 32'hA5A5A5A5, 0, 0);
      checkOutput();
      drive(mkStim(0,0,0,32'h0,8,8,1,8));
      drive(mkStim(0,1,8,32'h88,8,8,0,0));
      pushExp(0, "busy_byp", 32'h88, 32'h88, 0, 0);
      pushExp(1, "busy_byp", 0, 0, 1, 1);
      checkOutput();
      drive(mkStim(0,0,0,32'h0,8,8,0,0));
      pushExp(0, "busy_cleared", 32'h88, 32'h88, 0, 0);
      pushExp(1, "busy_cleared", 32'h88, 32'h88, 0, 0);
      checkOutput();

      // Out-of-range accesses and the top register of a non-power-of-two file
      drive(mkStim(0,1,25,32'h77777777,25,9,1,25));
      pushExp(0, "oor_write", 32'h77777777, 0, 1, 0);
      pushExp(1, "oor_write", 0, 0, 0, 0);
      checkOutput();
      drive(mkStim(0,0,0,32'h0,25,5,0,0));
      pushExp(0, "oor_read", 32'h77777777, 0, 1, 0);
      pushExp(1, "oor_read", 0, 0, 0, 0);
      checkOutput();
      drive(mkStim(0,1,19,32'h1,19,25,0,0));
      pushExp(0, "top_write", 32'h1, 32'h77777777, 0, 1);
      pushExp(1, "top_write", 0, 0, 0, 0);
      checkOutput();
      drive(mkStim(0,0,0,32'h0,19,19,0,0));
      pushExp(0, "top_read", 32'h1, 32'h1, 0, 0);
      pushExp(1, "top_read", 32'h1, 32'h1, 0, 0);
      checkOutput();

      // Randomised traffic against the reference model, with occasional resets
      drive(mkStim(1,0,0,32'h0,0,0,0,0));
      clearModel();
      for (int cyc = 0; cyc < 10000; cyc++) begin
         s = mkStim(($urandom_range(0, 299) == 0), ($urandom_range(0, 9) < 6), randAddr(),
                    $urandom(), randAddr(), randAddr(), ($urandom_range(0, 9) < 4), randAddr());
         drive(s);
         if (reset) clearModel();
         for (int k = 0; k < 2; k++) begin
            pushExp(k, $sformatf("rand%0d", cyc), expRdata(k, raddrA), expRdata(k, raddrB),
                    expBusy(k, raddrA), expBusy(k, raddrB));
         end
         checkOutput();
         modelStep();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
